demux_tdm: RTL and testbench
============================

DEMUX_TDM -- requirements
Module: demux_tdm

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the bits per channel sample.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port din, input, 1, the serial TDM data bit, MSB of each channel first.
REQ-005 The block SHALL have port sync, input, 1, the frame-start marker, high during the first bit of a frame.
REQ-006 The block SHALL have ports ch0, ch1, ch2, ch3, output, W each, holding the last complete frame's channel samples.
REQ-007 The block SHALL have port valid, output, 1, a one-cycle pulse marking that ch0..ch3 were just updated.
REQ-008 The block SHALL have port err, output, 1, a one-cycle pulse marking a framing error.

Function
REQ-009 A frame SHALL be 4*W consecutive bits (ch0 first), with sync high on bit 0 only.
REQ-010 The FSM SHALL have two states: IDLE (hunt for sync) and RECV (collect bits).
REQ-011 In IDLE with sync=1, the block SHALL take din as ch0 bit W-1, clear the channel/bit counters to position 1, and enter RECV.
REQ-012 In IDLE with sync=0, the block SHALL ignore din and hold all outputs.
REQ-013 In RECV, the block SHALL shift din into the current channel staging register each cycle, incrementing the bit counter and wrapping it to 0 with a channel-counter increment after W bits.
REQ-014 On the edge sampling bit 4*W-1, the block SHALL load ch0..ch3 simultaneously from staging, assert valid for the following cycle only, and return to IDLE.
REQ-015 Latency SHALL be one cycle: valid and new ch values are visible the cycle after the last bit is presented.
REQ-016 A sync=1 in the cycle immediately after a frame's last bit SHALL start a new frame with no gap, so back-to-back frames are supported.
REQ-017 A sync=1 in RECV at any position other than bit 0, including the last bit, SHALL pulse err for one cycle, discard the partial frame, leave ch0..ch3 and valid unchanged, and restart as if from IDLE with this bit as bit 0.
REQ-018 valid and err SHALL never be asserted in the same cycle.
REQ-019 ch0..ch3 SHALL change only on a valid pulse.

Reset
REQ-020 While rst=1, the FSM SHALL be IDLE, the counters and staging SHALL be 0, ch0..ch3 SHALL be 0, and valid and err SHALL be 0.
REQ-021 A reset mid-frame SHALL abandon the partial frame with no valid or err pulse; after release, the block SHALL hunt for sync.

Structure
REQ-022 A shared package demux_pkg SHALL hold the state encoding (IDLE=0, RECV=1), the constant N_CH=4, and the default W.
REQ-023 The W-bit serial-in shift register with load enable SHALL be a sub-module shreg, instantiated per channel (or once, with its output steered to staging).
REQ-024 Counter widths SHALL be clog2(W) for bits and 2 for channels; no combinational path SHALL run from din or sync to any output.

Verification
REQ-025 W=8, rst pulse, then frame A5,3C,0F,F0 -> valid=1 exactly one cycle after the 32nd bit; ch0=A5, ch1=3C, ch2=0F, ch3=F0; err=0.
REQ-026 Two back-to-back frames 11,22,33,44 then 55,66,77,88, with sync at bits 0 and 32 -> two valid pulses 32 cycles apart; the second set of values is shown after the second pulse.
REQ-027 Frame started, then sync=1 at bit 13 -> err pulse next cycle, no valid, outputs unchanged; the frame from bit 13 (DE,AD,BE,EF) -> valid with those values.
REQ-028 rst asserted asynchronously at bit 20 of a frame -> outputs 0 immediately; no valid; the next full frame decodes correctly.
REQ-029 100 cycles of toggling din with sync=0 from reset -> valid=0, err=0, ch0..ch3=0 throughout.
REQ-030 sync=1 on the 32nd bit of a frame -> err pulse, no valid; the subsequent 31 bits plus that bit complete a frame and pulse valid.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg
// Shared definitions for the TDM demultiplexer: FSM state encoding,
// number of TDM channels per frame and the default sample width.
// No ports (package only).

package demux_pkg;

  // Number of channels carried in one TDM frame
  localparam int N_CH = 4;

  // Default bits per channel sample
  localparam int W_DEFAULT = 8;

  // IDLE hunts for the frame-start marker, RECV collects frame bits
  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

endpackage

// File: rtl/demux_tdm_shreg.sv
// shreg
// W-bit serial-in / parallel-out shift register with a shift enable.
// New bits enter at the LSB, so after W enabled cycles the first bit
// shifted in sits at the MSB (MSB-first serial order).
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset, clears the register
//   en_i   - shift enable
//   din_i  - serial data bit
//   q_o    - parallel register contents (W bits)

module shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         din_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  // Shift left one position per enabled cycle, oldest bit drifts to MSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= {q_q[W-2:0], din_i};
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/demux_tdm.sv
// demux_tdm
// Serial TDM demultiplexer. A frame is N_CH*W bits, channel 0 first and
// MSB first within each channel, with sync high on bit 0 only. Each
// channel is collected in its own staging shift register; when the last
// bit arrives all four outputs are loaded together and valid pulses for
// one cycle. A sync seen mid-frame pulses err, drops the partial frame
// and restarts collection with that bit as the new bit 0.
// Ports:
//   clk         - clock, rising edge
//   rst         - asynchronous active-high reset
//   din         - serial TDM data bit
//   sync        - frame-start marker, high during bit 0 of a frame
//   ch0..ch3    - last complete frame's channel samples (W bits each)
//   valid       - one-cycle pulse, ch0..ch3 were just updated
//   err         - one-cycle pulse, framing error (sync mid-frame)

module demux_tdm
  import demux_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         din,
  input  logic         sync,
  output logic [W-1:0] ch0,
  output logic [W-1:0] ch1,
  output logic [W-1:0] ch2,
  output logic [W-1:0] ch3,
  output logic         valid,
  output logic         err
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
  localparam logic [1:0]    CH_LAST  = 2'(N_CH - 1);

  state_e          state_q;
  logic [BW-1:0]   bitCnt_q;
  logic [1:0]      chCnt_q;
  logic [W-1:0]    ch_q [N_CH];
  logic            valid_q;
  logic            err_q;

  logic [W-1:0]    stage [N_CH];
  logic [N_CH-1:0] shiftEn_d;
  logic [1:0]      shiftCh;
  logic            lastBit;
  logic [W-1:0]    lastChNext;

  // A sync always restarts at channel 0, whether hunting or mid-frame.
  // Otherwise only the channel currently being collected shifts.
  always_comb begin
    shiftEn_d = '0;
    shiftCh   = sync ? 2'd0 : chCnt_q;
    if (sync || (state_q == RECV)) begin
      shiftEn_d[shiftCh] = 1'b1;
    end
  end

  genvar c;
  generate
    for (c = 0; c < N_CH; c++) begin : gStage
      shreg #(.W(W)) uStage (
        .clk   (clk),
        .rst   (rst),
        .en_i  (shiftEn_d[c]),
        .din_i (din),
        .q_o   (stage[c])
      );
    end
  endgenerate

  assign lastBit = (chCnt_q == CH_LAST) && (bitCnt_q == BIT_LAST);

  // The final bit is still on din at the loading edge, so the last
  // channel is taken as its staging value shifted once more with din.
  assign lastChNext = (stage[N_CH-1] << 1) | W'(din);

  // Frame FSM with counters and registered outputs. valid and err are
  // cleared every cycle and only ever set on mutually exclusive paths.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bitCnt_q <= '0;
      chCnt_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        ch_q[i] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sync) begin
            state_q  <= RECV;
            bitCnt_q <= BW'(1);
            chCnt_q  <= '0;
          end
        end
        RECV: begin
          if (sync) begin
            // Bit 0 of a new frame arrived early: flag and resynchronise
            err_q    <= 1'b1;
            bitCnt_q <= BW'(1);
            chCnt_q  <= '0;
          end else if (lastBit) begin
            for (int i = 0; i < N_CH - 1; i++) begin
              ch_q[i] <= stage[i];
            end
            ch_q[N_CH-1] <= lastChNext;
            valid_q      <= 1'b1;
            state_q      <= IDLE;
            bitCnt_q     <= '0;
            chCnt_q      <= '0;
          end else if (bitCnt_q == BIT_LAST) begin
            bitCnt_q <= '0;
            chCnt_q  <= chCnt_q + 2'd1;
          end else begin
            bitCnt_q <= bitCnt_q + BW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ch0   = ch_q[0];
  assign ch1   = ch_q[1];
  assign ch2   = ch_q[2];
  assign ch3   = ch_q[3];
  assign valid = valid_q;
  assign err   = err_q;

endmodule

// File: tb/tb_demux_tdm.sv
// tb_demux_tdm
// Self-checking bench for demux_tdm (W=8). A reference model keeps the
// bits received since the last frame start in a queue and slices out
// the channel samples once a whole frame is present.

module tb_demux_tdm;

  localparam int W  = 8;
  localparam int FB = 4 * W;

  logic         clk  = 1'b0;
  logic         rst  = 1'b1;
  logic         din  = 1'b0;
  logic         sync = 1'b0;
  logic [W-1:0] ch0, ch1, ch2, ch3;
  logic         valid, err;

  int nCompared   = 0;
  int nMismatched = 0;
  int cycle       = 0;

  // Reference model state
  bit           mQ[$];
  bit           mHunt  = 1'b1;
  logic [W-1:0] mCh[4] = '{default: '0};
  logic         mValid = 1'b0;
  logic         mErr   = 1'b0;

  wire [2+4*W-1:0] dutVec = {valid, err, ch3, ch2, ch1, ch0};

  demux_tdm #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .sync  (sync),
    .ch0   (ch0),
    .ch1   (ch1),
    .ch2   (ch2),
    .ch3   (ch3),
    .valid (valid),
    .err   (err)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  function automatic logic [2+4*W-1:0] expVec();
    return {mValid, mErr, mCh[3], mCh[2], mCh[1], mCh[0]};
  endfunction

  task automatic modelReset();
    mQ.delete();
    mHunt  = 1'b1;
    mValid = 1'b0;
    mErr   = 1'b0;
    for (int c = 0; c < 4; c++) mCh[c] = '0;
  endtask

  // Drive one bit at the falling edge, let the DUT take it on the rising
  // edge, then advance the model with the same bit and sync value.
  task automatic applyStimulus(input logic d, input logic s);
    @(negedge clk);
    din  = d;
    sync = s;
    @(posedge clk);
    #1;
    cycle++;
    mValid = 1'b0;
    mErr   = 1'b0;
    if (s) begin
      if (!mHunt) mErr = 1'b1;
      mQ.delete();
      mQ.push_back(d);
      mHunt = 1'b0;
    end else if (!mHunt) begin
      mQ.push_back(d);
      if (mQ.size() == FB) begin
        for (int c = 0; c < 4; c++)
          for (int b = 0; b < W; b++)
            mCh[c][W-1-b] = mQ[c*W + b];
        mValid = 1'b1;
        mHunt  = 1'b1;
        mQ.delete();
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    nCompared++;
    if (dutVec !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_hold: got %h want 0", dutVec);
    end
    @(negedge clk);
    din  = 1'b1;
    sync = 1'b1;
    @(posedge clk);
    #1;
    nCompared++;
    if (dutVec !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_ignores_sync: got %h want 0", dutVec);
    end
    @(negedge clk);
    rst  = 1'b0;
    din  = 1'b0;
    sync = 1'b0;
    modelReset();
  endtask

  task automatic test_frame_a();
    logic [FB-1:0] f = 32'hA53C0FF0;
    for (int k = 0; k < FB; k++) begin
      applyStimulus(f[FB-1-k], k == 0);
      nCompared++;
      if (dutVec !== expVec()) begin
        nMismatched++;
        $display("[TB] FAIL frame_a bit %0d: got %h want %h", k, dutVec, expVec());
      end
    end
    nCompared++;
    if ({valid, err, ch0, ch1, ch2, ch3} !== {2'b10, 32'hA53C0FF0}) begin
      nMismatched++;
      $display("[TB] FAIL frame_a_values: got %h want %h",
               {valid, err, ch0, ch1, ch2, ch3}, {2'b10, 32'hA53C0FF0});
    end
    applyStimulus(1'b0, 1'b0);
    nCompared++;
    if ({valid, err, ch0, ch1, ch2, ch3} !== {2'b00, 32'hA53C0FF0}) begin
      nMismatched++;
      $display("[TB] FAIL frame_a_hold: got %h want %h",
               {valid, err, ch0, ch1, ch2, ch3}, {2'b00, 32'hA53C0FF0});
    end
  endtask

  task automatic test_back_to_back();
    logic [2*FB-1:0] f = 64'h11223344_55667788;
    int validAt[$];
    for (int k = 0; k < 2 * FB; k++) begin
      applyStimulus(f[2*FB-1-k], (k == 0) || (k == FB));
      if (valid === 1'b1) validAt.push_back(cycle);
      nCompared++;
      if (dutVec !== expVec()) begin
        nMismatched++;
        $display("[TB] FAIL back_to_back bit %0d: got %h want %h", k, dutVec, expVec());
      end
    end
    nCompared++;
    if (validAt.size() != 2) begin
      nMismatched++;
      $display("[TB] FAIL b2b_pulse_count: got %0d want 2", validAt.size());
    end else if (validAt[1] - validAt[0] != FB) begin
      nMismatched++;
      $display("[TB] FAIL b2b_spacing: got %0d want %0d", validAt[1] - validAt[0], FB);
    end
    nCompared++;
    if ({ch0, ch1, ch2, ch3} !== 32'h55667788) begin
      nMismatched++;
      $display("[TB] FAIL b2b_values: got %h want 55667788", {ch0, ch1, ch2, ch3});
    end
  endtask

  task automatic test_midframe_sync();
    logic [FB-1:0] junk = 32'h12345678;
    logic [FB-1:0] f    = 32'hDEADBEEF;
    for (int k = 0; k < 13; k++) begin
      applyStimulus(junk[FB-1-k], k == 0);
      nCompared++;
      if (dutVec !== expVec()) begin
        nMismatched++;
        $display("[TB] FAIL midsync_partial bit %0d: got %h want %h", k, dutVec, expVec());
      end
    end
    for (int k = 0; k < FB; k++) begin
      applyStimulus(f[FB-1-k], k == 0);
      nCompared++;
      if (dutVec !== expVec()) begin
        nMismatched++;
        $display("[TB] FAIL midsync_frame bit %0d: got %h want %h", k, dutVec, expVec());
      end
      if (k == 0) begin
        nCompared++;
        if ({valid, err, ch0, ch1, ch2, ch3} !== {2'b01, 32'h55667788}) begin
          nMismatched++;
          $display("[TB] FAIL midsync_err: got %h want %h",
                   {valid, err, ch0, ch1, ch2, ch3}, {2'b01, 32'h55667788});
        end
      end
    end
    nCompared++;
    if ({valid, err, ch0, ch1, ch2, ch3} !== {2'b10, 32'hDEADBEEF}) begin
      nMismatched++;
      $display("[TB] FAIL midsync_values: got %h want %h",
               {valid, err, ch0, ch1, ch2, ch3}, {2'b10, 32'hDEADBEEF});
    end
  endtask

  task automatic test_async_reset();
    logic [FB-1:0] junk = 32'hCAFEBABE;
    logic [FB-1:0] f    = 32'h13579BDF;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(junk[FB-1-k], k == 0);
    end
    #2;
    rst = 1'b1;
    #1;
    nCompared++;
    if (dutVec !== '0) begin
      nMismatched++;
      $display("[TB] FAIL async_reset_clear: got %h want 0", dutVec);
    end
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    for (int k = 0; k < FB; k++) begin
      applyStimulus(f[FB-1-k], k == 0);
      nCompared++;
      if (dutVec !== expVec()) begin
        nMismatched++;
        $display("[TB] FAIL post_reset_frame bit %0d: got %h want %h", k, dutVec, expVec());
      end
    end
    nCompared++;
    if ({valid, err, ch0, ch1, ch2, ch3} !== {2'b10, 32'h13579BDF}) begin
      nMismatched++;
      $display("[TB] FAIL post_reset_values: got %h want %h",
               {valid, err, ch0, ch1, ch2, ch3}, {2'b10, 32'h13579BDF});
    end
  endtask

  task automatic test_sync_last_bit();
    logic [FB-1:0] junk = 32'h0F1E2D3C;
    logic [FB-1:0] f    = 32'h5AA5C33C;
    for (int k = 0; k < FB - 1; k++) begin
      applyStimulus(junk[FB-1-k], k == 0);
    end
    for (int k = 0; k < FB; k++) begin
      applyStimulus(f[FB-1-k], k == 0);
      nCompared++;
      if (dutVec !== expVec()) begin
        nMismatched++;
        $display("[TB] FAIL lastbit_frame bit %0d: got %h want %h", k, dutVec, expVec());
      end
      if (k == 0) begin
        nCompared++;
        if ({valid, err, ch0, ch1, ch2, ch3} !== {2'b01, 32'h13579BDF}) begin
          nMismatched++;
          $display("[TB] FAIL lastbit_err: got %h want %h",
                   {valid, err, ch0, ch1, ch2, ch3}, {2'b01, 32'h13579BDF});
        end
      end
    end
    nCompared++;
    if ({valid, err, ch0, ch1, ch2, ch3} !== {2'b10, 32'h5AA5C33C}) begin
      nMismatched++;
      $display("[TB] FAIL lastbit_values: got %h want %h",
               {valid, err, ch0, ch1, ch2, ch3}, {2'b10, 32'h5AA5C33C});
    end
  endtask

  task automatic test_idle_noise();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    for (int i = 0; i < 100; i++) begin
      applyStimulus(i[0], 1'b0);
      nCompared++;
      if (dutVec !== '0) begin
        nMismatched++;
        $display("[TB] FAIL idle_noise cycle %0d: got %h want 0", i, dutVec);
      end
    end
  endtask

  task automatic test_random();
    int since = FB;
    logic s;
    for (int i = 0; i < 600; i++) begin
      s = ((since >= FB) && ($urandom_range(0, 3) != 0)) || ($urandom_range(0, 59) == 0);
      since = s ? 1 : since + 1;
      applyStimulus(1'($urandom_range(0, 1)), s);
      nCompared++;
      if (dutVec !== expVec()) begin
        nMismatched++;
        $display("[TB] FAIL random cycle %0d: got %h want %h", i, dutVec, expVec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_a();
    test_back_to_back();
    test_midframe_sync();
    test_async_reset();
    test_sync_last_bit();
    test_idle_noise();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
